// File: rtl/pc_pkg.sv
// Shared next-PC source encoding for the PC register and its flow counters.
package pc_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pc_src_t;

endpackage

// File: rtl/pc_flow_counters.sv
// Saturating taken-branch and jump counters; one-cycle update, no backpressure.
module pc_flow_counters #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             taken_i,
  input  logic             jump_i,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] jump_cnt_o
);

  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] jump_q, jump_d;

  // Counters stick at all-ones rather than wrapping back to zero.
  always_comb begin
    taken_d = taken_q;
    jump_d  = jump_q;
    if (taken_i && (taken_q != '1)) taken_d = taken_q + 1'b1;
    if (jump_i && (jump_q != '1))   jump_d  = jump_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      taken_q <= '0;
      jump_q  <= '0;
    end else begin
      taken_q <= taken_d;
      jump_q  <= jump_d;
    end
  end

  assign taken_cnt_o = taken_q;
  assign jump_cnt_o  = jump_q;

endmodule

// File: rtl/pc_next_unit.sv
// PC register and next-PC selector; new PC one cycle after PCWre, Halt freezes it.
// Flow counters are present only when BRANCH_COUNT_EN is defined.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             PCWre,
  input  logic             Halt,
  input  logic [1:0]       PCSrc,
  input  logic             BranchCond,
  input  logic [31:0]      ExtImm,
  input  logic [31:0]      RegData,
  input  logic [31:0]      JumpAddr,
  input  logic             MisalignClr,
  output logic [31:0]      PC,
  output logic [31:0]      PC4,
  output logic             Misalign,
  output logic [CNT_W-1:0] TakenCnt,
  output logic [CNT_W-1:0] JumpCnt
);

  logic [31:0] pc_q, pc_d;
  logic        mis_q, mis_d;
  logic        accept;
  logic        jr_aligned;
  pc_src_t     src;

  assign src        = pc_src_t'(PCSrc);
  assign accept     = PCWre && !Halt;
  assign jr_aligned = (RegData[1:0] == 2'b00);
  assign PC4        = pc_q + 32'd4;

  // The clear is applied first so that a misaligned jr in the same cycle overrides it.
  always_comb begin
    pc_d  = pc_q;
    mis_d = mis_q;
    if (MisalignClr) mis_d = 1'b0;
    if (accept) begin
      case (src)
        PCSRC_SEQ: pc_d = PC4;
        PCSRC_BR:  pc_d = BranchCond ? (PC4 + (ExtImm << 2)) : PC4;
        PCSRC_JR: begin
          if (jr_aligned) pc_d  = RegData;
          else            mis_d = 1'b1;
        end
        PCSRC_J:   pc_d = JumpAddr;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign PC       = pc_q;
  assign Misalign = mis_q;

`ifdef BRANCH_COUNT_EN
  logic taken_ev;
  logic jump_ev;

  assign taken_ev = accept && (src == PCSRC_BR) && BranchCond;
  assign jump_ev  = accept && ((src == PCSRC_J) || ((src == PCSRC_JR) && jr_aligned));

  pc_flow_counters #(
    .CNT_W (CNT_W)
  ) u_flow_counters (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .taken_i     (taken_ev),
    .jump_i      (jump_ev),
    .taken_cnt_o (TakenCnt),
    .jump_cnt_o  (JumpCnt)
  );
`else
  assign TakenCnt = '0;
  assign JumpCnt  = '0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed plus random checks of pc_next_unit against a behavioural next-PC model.
module tb_pc_next_unit;

  localparam int          TB_CNT_W = 4;
  localparam int          CMAX     = (1 << TB_CNT_W) - 1;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic                CLK = 1'b0;
  logic                RST_n = 1'b0;
  logic                PCWre = 1'b0;
  logic                Halt = 1'b0;
  logic [1:0]          PCSrc = 2'b00;
  logic                BranchCond = 1'b0;
  logic [31:0]         ExtImm = '0;
  logic [31:0]         RegData = '0;
  logic [31:0]         JumpAddr = '0;
  logic                MisalignClr = 1'b0;
  logic [31:0]         PC;
  logic [31:0]         PC4;
  logic                Misalign;
  logic [TB_CNT_W-1:0] TakenCnt;
  logic [TB_CNT_W-1:0] JumpCnt;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc = RST_PC;
  logic        exp_mis = 1'b0;
  int          exp_taken = 0;
  int          exp_jump = 0;

  pc_next_unit #(
    .RESET_PC (RST_PC),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .PCWre       (PCWre),
    .Halt        (Halt),
    .PCSrc       (PCSrc),
    .BranchCond  (BranchCond),
    .ExtImm      (ExtImm),
    .RegData     (RegData),
    .JumpAddr    (JumpAddr),
    .MisalignClr (MisalignClr),
    .PC          (PC),
    .PC4         (PC4),
    .Misalign    (Misalign),
    .TakenCnt    (TakenCnt),
    .JumpCnt     (JumpCnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    PC, exp_pc);
    check({tag, ".pc4"},   PC4, exp_pc + 32'd4);
    check({tag, ".mis"},   {31'd0, Misalign}, {31'd0, exp_mis});
    check({tag, ".taken"}, 32'(TakenCnt), 32'(exp_taken));
    check({tag, ".jump"},  32'(JumpCnt), 32'(exp_jump));
  endtask

  function automatic void bump(inout int cnt);
`ifdef BRANCH_COUNT_EN
    if (cnt < CMAX) cnt = cnt + 1;
`endif
  endfunction

  // One instruction slot: drive on the falling edge, predict, check just after the rising edge.
  task automatic step(input logic [1:0] src, input logic cond, input logic [31:0] imm,
                      input logic [31:0] rd, input logic [31:0] ja,
                      input logic clr, input logic halt, input logic we);
    logic [31:0] nxt;
    logic        set_mis;
    @(negedge CLK);
    PCSrc = src; BranchCond = cond; ExtImm = imm; RegData = rd;
    JumpAddr = ja; MisalignClr = clr; Halt = halt; PCWre = we;
    nxt = exp_pc;
    set_mis = 1'b0;
    if (we && !halt) begin
      if (src == 2'd0) nxt = exp_pc + 32'd4;
      else if (src == 2'd1) begin
        nxt = exp_pc + 32'd4 + (cond ? imm * 32'd4 : 32'd0);
        if (cond) bump(exp_taken);
      end else if (src == 2'd2) begin
        if (rd % 4 == 0) begin nxt = rd; bump(exp_jump); end
        else set_mis = 1'b1;
      end else begin
        nxt = ja;
        bump(exp_jump);
      end
    end
    @(posedge CLK);
    exp_pc  = nxt;
    exp_mis = set_mis ? 1'b1 : (clr ? 1'b0 : exp_mis);
    #1;
    PCWre = 1'b0; MisalignClr = 1'b0; Halt = 1'b0;
  endtask

  initial begin
    #2;
    check_all("reset0");
    @(negedge CLK);
    RST_n = 1'b1;

    // Mid-run asynchronous reset.
    step(2'd3, 0, 0, 0, 32'h40, 0, 0, 1);
    check_all("to40");
    #2;
    RST_n = 1'b0;
    #1;
    exp_pc = RST_PC; exp_mis = 0; exp_taken = 0; exp_jump = 0;
    check_all("async_rst");
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 0, 0, 0, 0, 0, 0, 1);
      check_all("seq");
    end
    check("seq_c", PC, 32'hC);

    // Backward branch taken / not taken.
    step(2'd3, 0, 0, 0, 32'h100, 0, 0, 1);
    step(2'd1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 1);
    check("br_taken", PC, 32'hFC);
    check_all("br_taken");
    step(2'd3, 0, 0, 0, 32'h100, 0, 0, 1);
    step(2'd1, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 1);
    check("br_not", PC, 32'h104);
    check_all("br_not");

    // Jump.
    step(2'd3, 0, 0, 0, 32'h1000_0000, 0, 0, 1);
    step(2'd3, 0, 0, 0, 32'h1000_0400, 0, 0, 1);
    check("jump", PC, 32'h1000_0400);
    check_all("jump");

    // Misaligned jr, set-wins, then clear alone.
    step(2'd2, 0, 0, 32'h0000_2002, 0, 0, 0, 1);
    check("mis_set", {31'd0, Misalign}, 32'd1);
    check_all("mis_set");
    step(2'd2, 0, 0, 32'h0000_2001, 0, 1, 0, 1);
    check_all("mis_setwins");
    step(2'd0, 0, 0, 0, 0, 1, 0, 0);
    check("mis_clr", {31'd0, Misalign}, 32'd0);
    check_all("mis_clr");
    step(2'd2, 0, 0, 32'h0000_2004, 0, 0, 0, 1);
    check_all("jr_ok");

    // Wrap-around and Halt.
    step(2'd3, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 1);
    step(2'd0, 0, 0, 0, 0, 0, 0, 1);
    check("wrap", PC, 32'h0);
    check_all("wrap");
    step(2'd3, 0, 0, 0, 32'h0000_0800, 0, 1, 1);
    check_all("halt_j");
    step(2'd2, 0, 0, 32'h3, 0, 0, 1, 1);
    check_all("halt_jr");
    step(2'd1, 1, 32'h10, 0, 0, 0, 1, 1);
    check_all("halt_br");
    step(2'd0, 0, 0, 0, 0, 0, 0, 0);
    check_all("idle");

    // Saturation of the taken counter.
    for (int i = 0; i < 17; i++) step(2'd1, 1, 32'h0, 0, 0, 0, 0, 1);
`ifdef BRANCH_COUNT_EN
    check("taken_sat", 32'(TakenCnt), 32'hF);
`else
    check("taken_off", 32'(TakenCnt), 32'h0);
`endif
    check_all("sat");

    // Random instruction mix.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rd;
      logic [31:0] imm;
      rd  = $urandom;
      if ($urandom_range(0, 1) == 0) rd[1:0] = 2'b00;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), imm, rd, $urandom,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0));
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
